// File: rtl/rob_commit_unit_pkg.sv
// rtl/rob_commit_unit_pkg.sv - shared RoB configuration and instruction type encodings
package rob_commit_unit_pkg;
    localparam int ROB_SIZE_WIDTH = 4;
    localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0] ROB_FULL_COUNT = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

    typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_STORE  = 2'd1,
        TYPE_BRANCH = 2'd2,
        TYPE_JALR   = 2'd3
    } inst_type_t;
endpackage

// File: rtl/rob_query_port.sv
// rtl/rob_query_port.sv - operand query: writeback bypass in front of the entry lookup
module rob_query_port
    import rob_commit_unit_pkg::*;
(
    input  logic                          ask_valid_unused_n,
    input  rob_id_t                       ask_rob_id,
    input  logic                          wb_alu_valid,
    input  rob_id_t                       wb_alu_rob_id,
    input  logic [31:0]                   wb_alu_value,
    input  logic                          wb_lsb_valid,
    input  rob_id_t                       wb_lsb_rob_id,
    input  logic [31:0]                   wb_lsb_value,
    input  logic [ROB_SIZE-1:0]           entry_ready,
    input  logic [ROB_SIZE-1:0][31:0]     entry_value,
    output logic [31:0]                   get_value,
    output logic                          get_ready
);
    logic unused_ok;
    assign unused_ok = ask_valid_unused_n;

    // ALU bus has priority, matching the capture order in the entry array
    always_comb begin
        get_value = entry_value[ask_rob_id];
        get_ready = entry_ready[ask_rob_id];
        if (wb_alu_valid && wb_alu_rob_id == ask_rob_id) begin
            get_value = wb_alu_value;
            get_ready = 1'b1;
        end else if (wb_lsb_valid && wb_lsb_rob_id == ask_rob_id) begin
            get_value = wb_lsb_value;
            get_ready = 1'b1;
        end
    end
endmodule

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - reorder buffer: allocate at issue, capture writebacks, retire in order
module rob_commit_unit
    import rob_commit_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       issue_valid,
    input  logic [1:0]                 issue_type,
    input  logic [4:0]                 issue_rd,
    input  logic                       issue_pred_jump,
    output logic                       rob_full,
    output logic [ROB_SIZE_WIDTH-1:0]  rob_tail_id,
    output logic [4:0]                 reg_issue_rd,
    output logic [ROB_SIZE_WIDTH-1:0]  reg_issue_rob_id,
    input  logic                       wb_alu_valid,
    input  logic [ROB_SIZE_WIDTH-1:0]  wb_alu_rob_id,
    input  logic [31:0]                wb_alu_value,
    input  logic                       wb_alu_jump,
    input  logic [31:0]                wb_alu_next_pc,
    input  logic                       wb_lsb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0]  wb_lsb_rob_id,
    input  logic [31:0]                wb_lsb_value,
    input  logic [ROB_SIZE_WIDTH-1:0]  ask_rob_id1,
    input  logic [ROB_SIZE_WIDTH-1:0]  ask_rob_id2,
    output logic [31:0]                get_value1,
    output logic [31:0]                get_value2,
    output logic                       get_ready1,
    output logic                       get_ready2,
    output logic [ROB_SIZE_WIDTH-1:0]  commit_rob_id,
    output logic [4:0]                 commit_rd,
    output logic [31:0]                commit_value,
    output logic                       commit_store_valid,
    output logic                       flush,
    output logic [31:0]                flush_pc
);
    localparam int CW = ROB_SIZE_WIDTH + 1;

    logic [ROB_SIZE-1:0]        busy_q, ready_q, pred_q, act_q;
    logic [ROB_SIZE-1:0][31:0]  value_q;
    inst_type_t                 type_q [ROB_SIZE];
    logic [4:0]                 rd_q   [ROB_SIZE];
    logic [31:0]                npc_q  [ROB_SIZE];
    rob_id_t                    head_q, tail_q;
    logic [CW-1:0]              count_q;

    logic       commit_fire, flush_now, issue_accept;
    inst_type_t head_type;

    assign rob_full         = (count_q == ROB_FULL_COUNT);
    assign rob_tail_id      = tail_q;
    assign reg_issue_rob_id = tail_q;
    assign head_type        = type_q[head_q];
    assign commit_fire      = busy_q[head_q] && ready_q[head_q];
    assign flush_now        = commit_fire && (head_type == TYPE_JALR ||
                              (head_type == TYPE_BRANCH && act_q[head_q] != pred_q[head_q]));
    // an issue in the flush-commit cycle belongs to the wrong path and is dropped
    assign issue_accept     = rdy && issue_valid && !rob_full && !flush_now;
    assign reg_issue_rd     = issue_accept ? issue_rd : 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            ready_q <= '0;
            pred_q  <= '0;
            act_q   <= '0;
            value_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                type_q[i] <= TYPE_REG;
                rd_q[i]   <= 5'd0;
                npc_q[i]  <= 32'd0;
            end
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            commit_rob_id      <= '0;
            commit_rd          <= 5'd0;
            commit_value       <= 32'd0;
            commit_store_valid <= 1'b0;
            flush              <= 1'b0;
            flush_pc           <= 32'd0;
        end else if (rdy) begin
            commit_rob_id      <= '0;
            commit_rd          <= 5'd0;
            commit_value       <= 32'd0;
            commit_store_valid <= 1'b0;
            flush              <= 1'b0;
            flush_pc           <= 32'd0;

            if (wb_lsb_valid && busy_q[wb_lsb_rob_id]) begin
                ready_q[wb_lsb_rob_id] <= 1'b1;
                value_q[wb_lsb_rob_id] <= wb_lsb_value;
            end
            if (wb_alu_valid && busy_q[wb_alu_rob_id]) begin
                ready_q[wb_alu_rob_id] <= 1'b1;
                value_q[wb_alu_rob_id] <= wb_alu_value;
                act_q[wb_alu_rob_id]   <= wb_alu_jump;
                npc_q[wb_alu_rob_id]   <= wb_alu_next_pc;
            end

            // ready/value stay behind so queries in the commit window still hit
            if (commit_fire) begin
                busy_q[head_q] <= 1'b0;
                head_q         <= head_q + rob_id_t'(1'b1);
                commit_rob_id  <= head_q;
                commit_value   <= value_q[head_q];
                case (head_type)
                    TYPE_REG:    commit_rd <= rd_q[head_q];
                    TYPE_STORE:  commit_store_valid <= 1'b1;
                    TYPE_BRANCH: begin
                        flush    <= flush_now;
                        flush_pc <= flush_now ? npc_q[head_q] : 32'd0;
                    end
                    TYPE_JALR: begin
                        commit_rd <= rd_q[head_q];
                        flush     <= 1'b1;
                        flush_pc  <= npc_q[head_q];
                    end
                    default: commit_rd <= 5'd0;
                endcase
            end

            if (issue_accept) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                type_q[tail_q]  <= inst_type_t'(issue_type);
                rd_q[tail_q]    <= issue_rd;
                pred_q[tail_q]  <= issue_pred_jump;
                tail_q          <= tail_q + rob_id_t'(1'b1);
            end

            count_q <= count_q + CW'(issue_accept) - CW'(commit_fire);

            if (flush_now) begin
                busy_q  <= '0;
                ready_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end
        end
    end

    rob_query_port u_query1 (
        .ask_valid_unused_n (1'b0),
        .ask_rob_id    (ask_rob_id1),
        .wb_alu_valid  (wb_alu_valid),
        .wb_alu_rob_id (wb_alu_rob_id),
        .wb_alu_value  (wb_alu_value),
        .wb_lsb_valid  (wb_lsb_valid),
        .wb_lsb_rob_id (wb_lsb_rob_id),
        .wb_lsb_value  (wb_lsb_value),
        .entry_ready   (ready_q),
        .entry_value   (value_q),
        .get_value     (get_value1),
        .get_ready     (get_ready1)
    );

    rob_query_port u_query2 (
        .ask_valid_unused_n (1'b0),
        .ask_rob_id    (ask_rob_id2),
        .wb_alu_valid  (wb_alu_valid),
        .wb_alu_rob_id (wb_alu_rob_id),
        .wb_alu_value  (wb_alu_value),
        .wb_lsb_valid  (wb_lsb_valid),
        .wb_lsb_rob_id (wb_lsb_rob_id),
        .wb_lsb_value  (wb_lsb_value),
        .entry_ready   (ready_q),
        .entry_value   (value_q),
        .get_value     (get_value2),
        .get_ready     (get_ready2)
    );
endmodule

// File: doc/rob_commit_unit.md
# rob_commit_unit

Reorder buffer for the out-of-order RISC-V core: a circular queue of in-flight instructions that allocates RoB ids at issue, captures results from the ALU and LSB writeback buses, and retires entries strictly in program order. It is the producer side of the register-file rename protocol. It drives the issue tag and the commit triple into the register file, and answers the register file's two combinational operand queries by RoB id. It also signals store commit to the LSB and raises the pipeline flush on a mispredicted branch or JALR.

## Interface
- ROB_SIZE_WIDTH, 4, log2 of entry count (16 entries); shared width of every RoB id
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; low freezes all state and registered outputs
- issue_valid  in  1  decoder issues one instruction this cycle
- issue_type  in  2  0 REG, 1 STORE, 2 BRANCH, 3 JALR
- issue_rd  in  5  destination register (0 = none)
- issue_pred_jump  in  1  predicted taken (BRANCH only)
- rob_full  out  1  no free entry; decoder must not issue
- rob_tail_id  out  W  id assigned to the next issued instruction
- reg_issue_rd  out  5  to register file; issue_rd when issue accepted, else 0
- reg_issue_rob_id  out  W  to register file; equals rob_tail_id
- wb_alu_valid / wb_alu_rob_id / wb_alu_value / wb_alu_jump / wb_alu_next_pc  in  1/W/32/1/32  ALU result bus
- wb_lsb_valid / wb_lsb_rob_id / wb_lsb_value  in  1/W/32  LSB result bus
- ask_rob_id1, ask_rob_id2  in  W  operand queries from register file
- get_value1, get_value2  out  32  combinational query results
- get_ready1, get_ready2  out  1  combinational query ready flags
- commit_rob_id  out  W  registered
- commit_rd  out  5  registered, 0 = no register write
- commit_value  out  32  registered
- commit_store_valid  out  1  registered one-cycle pulse to LSB
- flush  out  1  registered one-cycle pulse
- flush_pc  out  32  registered redirect target

## Operation
- Entry fields: busy, ready, type, rd, value, pred_jump, act_jump, next_pc. State: head, tail (W bits, natural wrap), count (W+1 bits).
- Issue is accepted when issue_valid && !rob_full. The entry at tail becomes busy=1, ready=0, and takes the issued fields. Tail increments. An issue while full is ignored with no state change.
- Writeback: a matching busy entry is set ready=1 and takes the value. The ALU bus also captures act_jump and next_pc. A writeback to a non-busy entry is ignored. If both buses target the same id, the ALU wins.
- Commit: when the head entry is busy && ready, retire it and increment head.
  - REG: commit_rd=rd.
  - STORE: commit_store_valid=1, commit_rd=0.
  - BRANCH: commit_rd=0. If act_jump != pred_jump, set flush=1 and flush_pc=next_pc.
  - JALR: commit_rd=rd, flush=1, flush_pc=next_pc.
- Committed entries clear busy but keep ready and value until they are reallocated. A query in the commit→register-file-update window still returns ready.
- Query, combinational for each port: if a writeback bus matches the ask id this cycle, return the bus value with ready=1. Otherwise return the entry's value and ready.
- count tracks accepted issues minus commits. rob_full = (count == 2^W).
- Flush: all busy and ready bits clear; head=tail=count=0. An issue presented in the flush-commit cycle is dropped. The decoder is already being redirected.

## Timing
- Reset values: all outputs 0, rob_full=0, rob_tail_id=0, all entries clear.
- An issue at edge N makes the entry visible from N. The earliest writeback to it is at edge N+1.
- Writeback at edge N gives ready from N (bypass makes it visible during cycle N). Commit is registered at edge N+1, and the register file updates at N+2.
- At most one commit per cycle. Commit outputs are valid for exactly one cycle; commit_rd returns to 0 when nothing commits.
- Simultaneous issue and commit while full: commit frees an entry, but the issue is still refused because rob_full is evaluated from the current count.
- When rdy=0, nothing advances and registered outputs hold.
- Asserting rst_n low mid-operation clears everything immediately, including a pending flush pulse.

## Structure
- The shared config header holds ROB_SIZE_WIDTH and the four type encodings.
- There is one natural sub-module, rob_query_port, instantiated twice; it implements the bypass and lookup mux.

## Test plan
- Reset, then issue REG rd=5 → rob_tail_id 0→1, reg_issue_rd=5. ALU writeback id 0 value 0x1234 → next cycle commit_rd=5, commit_value=0x1234, commit_rob_id=0.
- Issue 16 instructions without writeback → rob_full=1. A 17th issue leaves tail=0 (wrapped) and count=16. Completing id 0 → commit, rob_full=0.
- Writeback id 2 before ids 0 and 1 → no commit. After ids 0 and 1 complete, commits occur in order 0, 1, 2 on consecutive cycles.
- Issue BRANCH pred=0, ALU writeback jump=1 next_pc=0x100 → flush=1, flush_pc=0x100 for one cycle. Next cycle rob_tail_id=0, count=0.
- ask_rob_id1=3 while wb_lsb targets id 3 with 0xBEEF → same cycle get_ready1=1, get_value1=0xBEEF. The same query one cycle after id 3 commits still returns ready=1 with 0xBEEF.
- Assert rst_n low mid-commit → all outputs 0 asynchronously.
